symm_matmul_engine: RTL

SYMM_MATMUL_ENGINE -- requirements
Module: symm_matmul_engine

---
 rtl/symm_matmul_engine.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/symm_matmul_engine.sv
// rtl/symm_matmul_engine.sv - symmetric-input matrix multiplier C = A*B
//
// Loads the upper triangles of two symmetric N x N matrices A and B, one
// element of each per beat, in row-major order. It then computes the full
// C = A*B with one multiply-accumulate per cycle and streams out C
// row-major, one element per handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   valid_in, ready_in    load beat handshake
//   data_a, data_b        upper-triangle elements of A and B at the same position
//   valid_out, ready_out  result handshake
//   result, last_out      C[i][j] (signed); last_out flags C[N-1][N-1]
//   busy                  high whenever the engine is not idle
module symm_matmul_engine #(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int ACC_W = 2*W + $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic signed [W-1:0]     data_a,
    input  logic signed [W-1:0]     data_b,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic signed [ACC_W-1:0] result,
    output logic                    last_out,
    output logic                    busy
);

    localparam int T  = N*(N+1)/2;
    localparam int IW = $clog2(T);
    localparam int KW = $clog2(N);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           load_cnt_q, load_cnt_d;
    logic [KW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    logic signed [W-1:0]     a_mem [T];
    logic signed [W-1:0]     b_mem [T];
    logic signed [W-1:0]     a_op, b_op;
    logic signed [2*W-1:0]   prod;
    logic                    xfer;
    logic                    last_elem;

    // Triangle slot of (r,c). Lower-triangle coordinates are mirrored, so
    // only the upper triangle ever needs to be stored.
    function automatic logic [IW-1:0] tri_idx(input logic [KW-1:0] r_in,
                                              input logic [KW-1:0] c_in);
        int r;
        int c;
        if (r_in <= c_in) begin
            r = int'(r_in);
            c = int'(c_in);
        end else begin
            r = int'(c_in);
            c = int'(r_in);
        end
        // Row r starts after rows 0..r-1, which hold N, N-1, ... elements.
        return IW'(r*N - (r*(r-1))/2 + (c - r));
    endfunction

    assign xfer      = valid_in && ready_in;
    assign a_op      = a_mem[tri_idx(i_q, k_q)];
    assign b_op      = b_mem[tri_idx(k_q, j_q)];
    // The casts keep the signedness, so both operands are sign-extended
    // before the multiply.
    assign prod      = (2*W)'(a_op) * (2*W)'(b_op);
    assign last_elem = (i_q == KW'(N-1)) && (j_q == KW'(N-1));

    assign ready_in  = (state_q == IDLE) || (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign valid_out = (state_q == OUTPUT);
    assign last_out  = valid_out && last_elem;
    assign result    = acc_q;

    // The element store is not reset. The beat counter alone decides
    // which slots are valid.
    always_ff @(posedge clk) begin
        if (xfer) begin
            a_mem[load_cnt_q] <= data_a;
            b_mem[load_cnt_q] <= data_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    if (load_cnt_q == IW'(T-1)) begin
                        state_d    = COMPUTE;
                        load_cnt_d = '0;
                        i_d        = '0;
                        j_d        = '0;
                        k_d        = '0;
                    end else begin
                        state_d    = LOAD;
                        load_cnt_d = load_cnt_q + IW'(1);
                    end
                end
            end
            COMPUTE: begin
                // k == 0 starts a fresh dot product. The previous element's
                // sum is simply overwritten here.
                acc_d = ((k_q == '0) ? '0 : acc_q) + ACC_W'(prod);
                if (k_q == KW'(N-1)) begin
                    state_d = OUTPUT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            OUTPUT: begin
                if (ready_out) begin
                    if (last_elem) begin
                        state_d = IDLE;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        state_d = COMPUTE;
                        k_d     = '0;
                        if (j_q == KW'(N-1)) begin
                            j_d = '0;
                            i_d = i_q + KW'(1);
                        end else begin
                            j_d = j_q + KW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
